// File: rtl/airlock_pkg.sv
// airlock_pkg: shared encodings for the airlock controller.
//   state_e  - controller states
//   dir_e    - direction of the trip being served (0 = leave, 1 = arrive)
//   SEG_*    - active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
package airlock_pkg;
  typedef enum logic [2:0] {
    IDLE, IN_OPEN_WAIT, IN_CLOSE_WAIT, EVAC, OUT_OPEN_WAIT, OUT_CLOSE_WAIT, PRESS, FAULT
  } state_e;
  typedef enum logic {DIR_LEAVE = 1'b0, DIR_ARRIVE = 1'b1} dir_e;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_P = 7'b0001100;
  localparam logic [6:0] SEG_F = 7'b0001110;
  localparam logic [6:0] SEG_L = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/airlock_if.sv
// airlock_if: request, sensor and actuator bundle of the airlock controller.
//   master: drives arrive_req, leave_req, tick, inner_open, outer_open
//   slave : drives grant_arrive, grant_leave, inner_unlock, outer_unlock,
//           evac_cmd, press_cmd, alarm, display[6:0]
interface airlock_if;
  logic arrive_req, leave_req, tick, inner_open, outer_open;
  logic grant_arrive, grant_leave, inner_unlock, outer_unlock, evac_cmd, press_cmd, alarm;
  logic [6:0] display;
  modport master (
    output arrive_req, leave_req, tick, inner_open, outer_open,
    input grant_arrive, grant_leave, inner_unlock, outer_unlock, evac_cmd, press_cmd, alarm, display
  );
  modport slave (
    input arrive_req, leave_req, tick, inner_open, outer_open,
    output grant_arrive, grant_leave, inner_unlock, outer_unlock, evac_cmd, press_cmd, alarm, display
  );
endinterface

// File: rtl/airlock_tick_timer.sv
// airlock_tick_timer: counts tick pulses while enabled; done marks the tick
// that completes 'limit' counted ticks.
//   clock, rst (async, active-low), clear (sync, wins over counting),
//   enable, tick, limit[CW-1:0] -> done
module airlock_tick_timer #(
  parameter int CW = 3
) (
  input  logic          clock,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic          tick,
  input  logic [CW-1:0] limit,
  output logic          done
);
  logic [CW-1:0] count;
  always_ff @(posedge clock or negedge rst)
    if (!rst) count <= '0;
    else if (clear) count <= '0;
    else if (enable && tick) count <= count + 1'b1;
  assign done = enable && tick && count == limit - 1'b1;
endmodule

// File: rtl/airlock_scheduler.sv
// airlock_scheduler: arbitrates arrival/departure requests for one airlock,
// sequences the doors, times evacuate/pressurize and drives the status display.
//   clock, rst (async, active-low)
//   bus (airlock_if.slave): requests, tick and door sensors in;
//                           grants, unlocks, pump/valve commands, alarm, display out
// Optional: define AIRLOCK_TIMEOUT_EN to abort a trip whose door stays closed
// for TIMEOUT_TICKS ticks in an open-wait state.
module airlock_scheduler import airlock_pkg::*; #(
  parameter int EVAC_TICKS = 2,
  parameter int PRESS_TICKS = 4,
  parameter int TIMEOUT_TICKS = 6,
  parameter int CW = 3
) (
  input logic clock,
  input logic rst,
  airlock_if.slave bus
);
  state_e state, nextState;
  dir_e dir, nextDir, lastServed, nextLastServed;
  logic skipInner, nextSkip;
  logic innerUnlock, outerUnlock, faultNow, pickLeave, timerEn, timerDone;
  logic [CW-1:0] limit;
  assign innerUnlock = state inside {IN_OPEN_WAIT, IN_CLOSE_WAIT};
  assign outerUnlock = state inside {OUT_OPEN_WAIT, OUT_CLOSE_WAIT};
  assign faultNow = (bus.inner_open && bus.outer_open) || (bus.inner_open && !innerUnlock)
                 || (bus.outer_open && !outerUnlock);
  // On a tie the side not served last time wins.
  assign pickLeave = bus.leave_req && (!bus.arrive_req || lastServed == DIR_ARRIVE);
  assign limit = state == EVAC ? CW'(EVAC_TICKS) : state == PRESS ? CW'(PRESS_TICKS) : CW'(TIMEOUT_TICKS);
`ifdef AIRLOCK_TIMEOUT_EN
  assign timerEn = state inside {EVAC, PRESS, IN_OPEN_WAIT, OUT_OPEN_WAIT};
`else
  assign timerEn = state inside {EVAC, PRESS};
`endif
  airlock_tick_timer #(.CW(CW)) timer (
    .clock(clock), .rst(rst), .clear(nextState != state), .enable(timerEn),
    .tick(bus.tick), .limit(limit), .done(timerDone)
  );
  // In the open-wait states timerDone can only be a timeout; without the
  // timeout build the timer is disabled there and it stays low.
  always_comb begin
    nextState = state;
    nextDir = dir;
    nextLastServed = lastServed;
    nextSkip = skipInner;
    case (state)
      IDLE: begin
        nextSkip = 1'b0;
        if (bus.arrive_req || bus.leave_req) begin
          nextDir = pickLeave ? DIR_LEAVE : DIR_ARRIVE;
          nextLastServed = nextDir;
          nextState = pickLeave ? IN_OPEN_WAIT : EVAC;
        end
      end
      IN_OPEN_WAIT: nextState = bus.inner_open ? IN_CLOSE_WAIT : timerDone ? IDLE : IN_OPEN_WAIT;
      IN_CLOSE_WAIT: nextState = bus.inner_open ? IN_CLOSE_WAIT : dir == DIR_LEAVE ? EVAC : IDLE;
      EVAC: nextState = timerDone ? OUT_OPEN_WAIT : EVAC;
      OUT_OPEN_WAIT: begin
        // Timed out with the chamber evacuated: repressurize, then skip the inner door.
        nextState = bus.outer_open ? OUT_CLOSE_WAIT : timerDone ? PRESS : OUT_OPEN_WAIT;
        nextSkip = !bus.outer_open && timerDone;
      end
      OUT_CLOSE_WAIT: nextState = bus.outer_open ? OUT_CLOSE_WAIT : PRESS;
      PRESS: nextState = !timerDone ? PRESS : (dir == DIR_LEAVE || skipInner) ? IDLE : IN_OPEN_WAIT;
      default: nextState = FAULT;
    endcase
    if (faultNow) nextState = FAULT;
  end
  always_ff @(posedge clock or negedge rst)
    if (!rst) begin
      state <= IDLE;
      dir <= DIR_LEAVE;
      lastServed <= DIR_ARRIVE;
      skipInner <= 1'b0;
    end else begin
      state <= nextState;
      dir <= nextDir;
      lastServed <= nextLastServed;
      skipInner <= nextSkip;
    end
  assign bus.grant_leave = state != IDLE && state != FAULT && dir == DIR_LEAVE;
  assign bus.grant_arrive = state != IDLE && state != FAULT && dir == DIR_ARRIVE;
  assign bus.inner_unlock = innerUnlock;
  assign bus.outer_unlock = outerUnlock;
  assign bus.evac_cmd = state == EVAC;
  assign bus.press_cmd = state == PRESS;
  assign bus.alarm = state == FAULT;
  assign bus.display = state == EVAC ? SEG_E : state == PRESS ? SEG_P : state == FAULT ? SEG_F
                     : (state == IN_OPEN_WAIT && dir == DIR_LEAVE) ? SEG_L : SEG_BLANK;
endmodule

// File: tb/tb_airlock_scheduler.sv
// tb_airlock_scheduler: directed table, corner-case sequences and randomized
// traffic checked against a trip-route model of the airlock.
module tb_airlock_scheduler;
  localparam int EVAC_N = 2, PRESS_N = 4, TIMEOUT_N = 6;
  localparam int P_IDLE = 0, P_IN_OPEN = 1, P_IN_CLOSE = 2, P_EVAC = 3, P_OUT_OPEN = 4, P_OUT_CLOSE = 5, P_PRESS = 6;
  localparam logic [13:0] IDLE_OUT = {7'b0000000, 7'b1111111};
  logic clock = 1'b0;
  logic rst = 1'b0;
  airlock_if bus();
  airlock_scheduler #(.EVAC_TICKS(EVAC_N), .PRESS_TICKS(PRESS_N), .TIMEOUT_TICKS(TIMEOUT_N), .CW(3)) dut (
    .clock(clock), .rst(rst), .bus(bus)
  );
  always #5 clock = ~clock;
  logic [13:0] dutOut;
  assign dutOut = {bus.grant_arrive, bus.grant_leave, bus.inner_unlock, bus.outer_unlock,
                   bus.evac_cmd, bus.press_cmd, bus.alarm, bus.display};
  int passed = 0, total = 0;
  // Model: the remaining phases of the current trip; empty means idle.
  int route[$];
  bit mFault, mArrive, mLastArrive;
  int mTicks;
  typedef struct packed {
    logic [4:0] in;
    logic [6:0] out;
    logic [6:0] seg;
  } vec_t;
  vec_t vecs[13];
  logic ar, lv, io, oo, innerSeen;
  logic [13:0] e;
  int p;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  function automatic int curPhase();
    return route.size() != 0 ? route[0] : P_IDLE;
  endfunction

  function automatic void modelReset();
    route.delete();
    mFault = 0;
    mArrive = 0;
    mLastArrive = 1;
    mTicks = 0;
  endfunction

  function automatic void advance();
    void'(route.pop_front());
    mTicks = 0;
  endfunction

  function automatic logic [13:0] modelOut();
    int ph;
    logic busy;
    logic [6:0] seg;
    ph = curPhase();
    busy = !mFault && route.size() != 0;
    seg = mFault ? 7'b0001110 : ph == P_EVAC ? 7'b0000110 : ph == P_PRESS ? 7'b0001100
        : (ph == P_IN_OPEN && !mArrive) ? 7'b1000111 : 7'b1111111;
    return {busy && mArrive, busy && !mArrive, ph == P_IN_OPEN || ph == P_IN_CLOSE,
            ph == P_OUT_OPEN || ph == P_OUT_CLOSE, ph == P_EVAC, ph == P_PRESS, mFault, seg};
  endfunction

  task automatic modelStep();
    int ph;
    logic di, dou;
    di = bus.inner_open;
    dou = bus.outer_open;
    if (!rst) begin
      modelReset();
      return;
    end
    if (mFault) return;
    ph = curPhase();
    if ((di && dou) || (di && !(ph == P_IN_OPEN || ph == P_IN_CLOSE)) || (dou && !(ph == P_OUT_OPEN || ph == P_OUT_CLOSE))) begin
      mFault = 1;
      route.delete();
      return;
    end
    if (ph == P_IDLE) begin
      if (bus.arrive_req || bus.leave_req) begin
        mArrive = !(bus.leave_req && (!bus.arrive_req || mLastArrive));
        mLastArrive = mArrive;
        mTicks = 0;
        if (mArrive) route = '{P_EVAC, P_OUT_OPEN, P_OUT_CLOSE, P_PRESS, P_IN_OPEN, P_IN_CLOSE};
        else route = '{P_IN_OPEN, P_IN_CLOSE, P_EVAC, P_OUT_OPEN, P_OUT_CLOSE, P_PRESS};
      end
      return;
    end
    if ((ph == P_IN_OPEN && di) || (ph == P_OUT_OPEN && dou) || (ph == P_IN_CLOSE && !di) || (ph == P_OUT_CLOSE && !dou)) begin
      advance();
      return;
    end
    if (bus.tick) mTicks++;
    if ((ph == P_EVAC && mTicks == EVAC_N) || (ph == P_PRESS && mTicks == PRESS_N)) advance();
`ifdef AIRLOCK_TIMEOUT_EN
    else if ((ph == P_IN_OPEN || ph == P_OUT_OPEN) && mTicks == TIMEOUT_N) begin
      mTicks = 0;
      route.delete();
      if (ph == P_OUT_OPEN) route.push_back(P_PRESS);
    end
`endif
  endtask

  task automatic drive(input logic a, input logic l, input logic t, input logic i, input logic o);
    bus.arrive_req = a;
    bus.leave_req = l;
    bus.tick = t;
    bus.inner_open = i;
    bus.outer_open = o;
  endtask

  task automatic clk1(input string name);
    @(posedge clock);
    modelStep();
    #1;
    check(name, dutOut, modelOut());
  endtask

  task automatic pulseReset(input logic holdArrive);
    @(negedge clock);
    rst = 1'b0;
    drive(holdArrive, 0, 0, 0, 0);
    #1;
    modelReset();
    check("async reset", dutOut, IDLE_OUT);
    @(negedge clock);
    rst = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{5'b01000, 7'b0110000, 7'b1000111};
    vecs[1]  = '{5'b00010, 7'b0110000, 7'b1111111};
    vecs[2]  = '{5'b00100, 7'b0100100, 7'b0000110};
    vecs[3]  = '{5'b00100, 7'b0100100, 7'b0000110};
    vecs[4]  = '{5'b00000, 7'b0100100, 7'b0000110};
    vecs[5]  = '{5'b00100, 7'b0101000, 7'b1111111};
    vecs[6]  = '{5'b00001, 7'b0101000, 7'b1111111};
    vecs[7]  = '{5'b00000, 7'b0100010, 7'b0001100};
    vecs[8]  = '{5'b00100, 7'b0100010, 7'b0001100};
    vecs[9]  = '{5'b00100, 7'b0100010, 7'b0001100};
    vecs[10] = '{5'b00000, 7'b0100010, 7'b0001100};
    vecs[11] = '{5'b00100, 7'b0100010, 7'b0001100};
    vecs[12] = '{5'b00100, 7'b0000000, 7'b1111111};
    drive(0, 0, 0, 0, 0);
    modelReset();
    #1;
    check("reset state", dutOut, IDLE_OUT);
    @(negedge clock);
    rst = 1'b1;
    // Leave-only trip; the tick that enters EVAC is not counted.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].in[4], vecs[i].in[3], vecs[i].in[2], vecs[i].in[1], vecs[i].in[0]);
      clk1($sformatf("model vec%0d", i));
      check($sformatf("vec%0d", i), dutOut, {vecs[i].out, vecs[i].seg});
    end
    // Simultaneous requests: departure first, arrival right after.
    pulseReset(0);
    drive(1, 1, 0, 0, 0); clk1("both");
    check("tie leave first", {bus.grant_leave, bus.grant_arrive}, 2'b10);
    drive(1, 0, 0, 1, 0); clk1("tie inopen");
    drive(1, 0, 0, 0, 0); clk1("tie inclose");
    drive(1, 0, 1, 0, 0); clk1("tie evac1"); clk1("tie evac2");
    drive(1, 0, 0, 0, 1); clk1("tie outopen");
    drive(1, 0, 0, 0, 0); clk1("tie outclose");
    drive(1, 0, 1, 0, 0);
    repeat (4) clk1("tie press");
    check("tie idle between", dutOut, IDLE_OUT);
    clk1("tie arrive accept");
    check("arrive enters evac", dutOut, {7'b1000100, 7'b0000110});
    drive(0, 0, 1, 0, 0); clk1("arrive tick1");
    check("entry tick uncounted", bus.evac_cmd, 1'b1);
    clk1("arrive tick2");
    check("evac over", {bus.evac_cmd, bus.outer_unlock}, 2'b01);
    drive(0, 0, 0, 0, 1); clk1("arr outopen");
    drive(0, 0, 0, 0, 0); clk1("arr outclose");
    drive(0, 0, 1, 0, 0);
    repeat (4) clk1("arr press");
    check("arrive inner open", dutOut, {7'b1010000, 7'b1111111});
    drive(0, 0, 0, 1, 0); clk1("arr inopen");
    drive(0, 0, 0, 0, 0); clk1("arr inclose");
    check("arrive done", dutOut, IDLE_OUT);
    // Outer door opened during EVAC latches a fault until reset.
    drive(1, 0, 0, 0, 0); clk1("flt accept");
    drive(0, 0, 0, 0, 1); clk1("flt door");
    check("fault latched", dutOut, {7'b0000001, 7'b0001110});
    for (int i = 0; i < 5; i++) begin
      drive(i[0], !i[0], 1, 0, 0);
      clk1("flt hold");
      check("fault holds", {bus.alarm, bus.display}, {1'b1, 7'b0001110});
    end
    // Asynchronous reset mid-PRESS with arrive held.
    pulseReset(0);
    drive(1, 0, 0, 0, 0); clk1("rp accept");
    drive(1, 0, 1, 0, 0); clk1("rp evac1"); clk1("rp evac2");
    drive(1, 0, 0, 0, 1); clk1("rp outopen");
    drive(1, 0, 0, 0, 0); clk1("rp outclose");
    drive(1, 0, 1, 0, 0); clk1("rp press1");
    check("in press", bus.press_cmd, 1'b1);
    pulseReset(1);
    clk1("rp reaccept");
    check("held arrive served", {bus.grant_arrive, bus.evac_cmd}, 2'b11);
`ifdef AIRLOCK_TIMEOUT_EN
    // Outer door never opens: timeout, repressurize, skip inner door.
    pulseReset(0);
    innerSeen = 0;
    drive(1, 0, 0, 0, 0); clk1("to accept");
    drive(0, 0, 1, 0, 0); clk1("to evac1"); clk1("to evac2");
    for (int i = 0; i < 6; i++) begin
      check("to waiting", bus.outer_unlock, 1'b1);
      clk1("to tick");
    end
    check("to press", bus.press_cmd, 1'b1);
    for (int i = 0; i < 6; i++) begin
      clk1("to tail");
      innerSeen |= bus.inner_unlock;
    end
    check("to idle", dutOut, IDLE_OUT);
    check("to no inner", innerSeen, 1'b0);
`endif
    // Randomized traffic against the model.
    pulseReset(0);
    ar = 0; lv = 0; io = 0; oo = 0;
    for (int n = 0; n < 3000; n++) begin
      e = modelOut();
      p = curPhase();
      ar = ar ? !e[13] : ($urandom_range(0, 5) == 0);
      lv = lv ? !e[12] : ($urandom_range(0, 5) == 0);
      io = p == P_IN_OPEN ? (io | ($urandom_range(0, 3) == 0)) : p == P_IN_CLOSE ? (io & ($urandom_range(0, 2) != 0)) : 1'b0;
      oo = p == P_OUT_OPEN ? (oo | ($urandom_range(0, 3) == 0)) : p == P_OUT_CLOSE ? (oo & ($urandom_range(0, 2) != 0)) : 1'b0;
      if ($urandom_range(0, 150) == 0) begin
        if ($urandom_range(0, 1) == 1) io = 1;
        else oo = 1;
      end
      drive(ar, lv, $urandom_range(0, 2) == 0, io, oo);
      if (mFault && $urandom_range(0, 7) == 0) begin
        pulseReset(0);
        ar = 0; lv = 0; io = 0; oo = 0;
      end else clk1("random");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/airlock_scheduler.md
Name: airlock_scheduler

Overview:
Controller that shares the single habitat airlock between two requesters: arrivals from outside and departures from inside. It arbitrates the requests and sequences the doors. It also times the evacuate and pressurize phases using an internal tick counter, and drives the airlock's 7-segment status display. It sits between the crew request buttons, the door sensors and the pump/valve drivers.

Parameters:
EVAC_TICKS, 2, number of tick pulses the chamber stays in the evacuate phase (must be ≥1)
PRESS_TICKS, 4, number of tick pulses the chamber stays in the pressurize phase (must be ≥1)
TIMEOUT_TICKS, 6, wait limit for door-open states; used only with the optional feature
CW, 3, width of the tick counter; must hold max(EVAC_TICKS, PRESS_TICKS, TIMEOUT_TICKS)

Ports:
clock  in  1  system clock
rst  in  1  asynchronous, active-low reset
arrive_req  in  1  level request from outside; held until grant_arrive is seen
leave_req  in  1  level request from inside; held until grant_leave is seen
tick  in  1  one-cycle timebase pulse
inner_open  in  1  inner door sensor, 1 = open
outer_open  in  1  outer door sensor, 1 = open
grant_arrive  out  1  airlock is serving an arrival
grant_leave  out  1  airlock is serving a departure
inner_unlock  out  1  inner door released
outer_unlock  out  1  outer door released
evac_cmd  out  1  pump-down active
press_cmd  out  1  pressurize valve active
alarm  out  1  fault latched
display  out  7  active-low 7-segment code

Behaviour:
- Reset: when rst is low, all registers clear immediately (no clock edge needed). State = IDLE; all outputs 0; display = blank (1111111); counter = 0; last_served = arrive.
- All outputs are Moore, decoded from registered state and the registered dir bit. Outputs therefore lag the input that causes a transition by 1 cycle.
- States: IDLE, IN_OPEN_WAIT, IN_CLOSE_WAIT, EVAC, OUT_OPEN_WAIT, OUT_CLOSE_WAIT, PRESS, FAULT.
- Arbitration in IDLE:
  - If only one request is high, serve it.
  - If both are high, serve the opposite of last_served, so a departure wins first after reset.
  - On acceptance: set dir (0 = leave, 1 = arrive), update last_served.
  - Next state: leave → IN_OPEN_WAIT; arrive → EVAC.
- Leave path: IN_OPEN_WAIT --inner_open--> IN_CLOSE_WAIT --~inner_open--> EVAC --timer done--> OUT_OPEN_WAIT --outer_open--> OUT_CLOSE_WAIT --~outer_open--> PRESS --timer done--> IDLE.
- Arrive path: EVAC → OUT_OPEN_WAIT → OUT_CLOSE_WAIT → PRESS → IN_OPEN_WAIT → IN_CLOSE_WAIT → IDLE, using the same edge conditions as the leave path.
- inner_unlock = 1 in IN_OPEN_WAIT and IN_CLOSE_WAIT. outer_unlock = 1 in OUT_OPEN_WAIT and OUT_CLOSE_WAIT.
- evac_cmd = 1 in EVAC; press_cmd = 1 in PRESS.
- grant_leave = (state ≠ IDLE, ≠ FAULT, and dir = 0). grant_arrive uses dir = 1 with the same state conditions.
- Timer:
  - Counter clears on every state change.
  - It increments on tick only while in EVAC or PRESS.
  - "Done" = tick & (count == N−1), where N is the phase's tick parameter. This gives exactly N ticks observed in the state.
  - A tick on the entry (transition) cycle is not counted.
- Fault, checked every cycle, higher priority than any other transition:
  - both doors open at once; or
  - a door open in a state where its unlock output is 0 (this includes IDLE, EVAC and PRESS).
  - Result → FAULT: all unlock/cmd/grant outputs = 0, alarm = 1. FAULT is left only by reset.
- Display codes: EVAC = E (0000110); PRESS = P (0001100); FAULT = F (0001110); IN_OPEN_WAIT with dir = 0 = L (1000111); all other states blank.
- Requests that arrive while the airlock is busy are not queued internally; they stay pending by being held high.

Optional Feature:
- Macro: AIRLOCK_TIMEOUT_EN.
- When defined, the counter also runs in IN_OPEN_WAIT and OUT_OPEN_WAIT. If TIMEOUT_TICKS ticks pass with the door still closed, the cycle aborts:
  - leave at IN_OPEN_WAIT → IDLE;
  - arrive at OUT_OPEN_WAIT (chamber is evacuated) → PRESS, then IDLE (the inner door phase is skipped);
  - arrive at IN_OPEN_WAIT → IDLE.
  - last_served is still updated as normal.
- When not defined, the open-wait states wait forever.

Decomposition:
- Package airlock_pkg holds:
  - the state enum;
  - the dir encoding;
  - the segment constants SEG_E, SEG_P, SEG_F, SEG_L, SEG_BLANK.
- One sub-module, airlock_tick_timer, contains the counter. Its interface: clear, enable, tick, limit → done.

Test Plan:
1. Leave only, default parameters:
   - Stimulus: leave_req = 1; pulse inner_open 1 then 0; supply ticks.
   - Required: grant_leave and inner_unlock go high 1 cycle after acceptance; evac_cmd stays high for exactly 2 ticks; outer_unlock follows; after outer_open 1→0, press_cmd stays high for 4 ticks; then IDLE with all outputs 0.
2. arrive_req and leave_req raised in the same cycle after reset:
   - Required: departure served first; arrival served immediately after return to IDLE, entering EVAC.
3. outer_open = 1 during EVAC:
   - Required: next cycle alarm = 1, display = 0001110, evac_cmd = 0; remains in FAULT through further ticks and requests until rst is pulsed low.
4. rst driven low mid-PRESS, between clock edges:
   - Required: press_cmd and grant drop to 0 without a clock edge; after release, IDLE, and a held arrive_req is served.
5. Tick coincident with the transition into EVAC:
   - Required: that tick is not counted; evac_cmd still spans 2 further ticks.
6. With AIRLOCK_TIMEOUT_EN, arrival, outer door never opened:
   - Required: after 6 ticks in OUT_OPEN_WAIT, go to PRESS for 4 ticks, then IDLE; inner_unlock never asserts.
